pipe_stage_reg: RTL and testbench

Parametrised, flow-controlled pipeline stage register that supersedes the fixed decode-to-execute latch. It carries a datapath bundle and a control bundle between any two CPU_NN pipeline stages with a valid/ready handshake, stall, and flush (bubble insertion). An optional skid slot breaks the combinational ready path. A saturating stall counter supports performance analysis.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_slot.sv | 38 +++
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the CPU pipeline stage registers: bus and register
// index widths, control-bundle bit offsets and the bubble control value.
package pipe_pkg;

    localparam int BUS_WIDTH      = 32;
    localparam int REGISTER_SIZE  = 6;
    localparam int ALU_FUNCT_BITS = 3;

    // Bit offsets of the fields packed into the control bundle
    localparam int CTRL_PCEN_BIT      = 0;
    localparam int CTRL_REGWRITE_BIT  = 1;
    localparam int CTRL_ALU1SRC_BIT   = 2;
    localparam int CTRL_REGDST_BIT    = 3;
    localparam int CTRL_ALU1CNTRL_LSB = 4;
    localparam int CTRL_ALU2CNTRL_LSB = CTRL_ALU1CNTRL_LSB + ALU_FUNCT_BITS;
    localparam int CTRL_MEMWRITE_BIT  = CTRL_ALU2CNTRL_LSB + ALU_FUNCT_BITS;
    localparam int CTRL_MEMTOREG_BIT  = CTRL_MEMWRITE_BIT + 1;

    // A bubble keeps the PC advancing but performs no register or memory write
    localparam logic [15:0] CTRL_RST_VAL_DEFAULT = 16'(1) << CTRL_PCEN_BIT;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid bit, datapath bundle and control
// bundle. Clear wins over load; a cleared slot keeps its data but parks its
// control bundle at the bubble value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 128,
    parameter int                    CTRL_WIDTH   = 16,
    parameter logic [CTRL_WIDTH-1:0] CTRL_RST_VAL = CTRL_WIDTH'(CTRL_RST_VAL_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [CTRL_WIDTH-1:0] load_ctrl,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CTRL_WIDTH-1:0] ctrl
);

    // Slot register: reset, then clear, then load in priority order
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_RST_VAL;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_RST_VAL;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with flush/bubble insertion and a
// saturating stall counter. Define PIPE_SKID_EN to add a skid slot, which makes
// InReady a registered signal with no path from OutReady.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 128,
    parameter int                    CTRL_WIDTH   = 16,
    parameter logic [CTRL_WIDTH-1:0] CTRL_RST_VAL = CTRL_WIDTH'(CTRL_RST_VAL_DEFAULT),
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Flush,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DATA_WIDTH-1:0] InData,
    input  logic [CTRL_WIDTH-1:0] InCtrl,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic [CTRL_WIDTH-1:0] OutCtrl,
    output logic [CNT_WIDTH-1:0]  StallCount
);

    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic                  main_free;
    logic                  in_xfer;
    logic                  main_load;
    logic                  main_clear;
    logic [DATA_WIDTH-1:0] main_load_data;
    logic [CTRL_WIDTH-1:0] main_load_ctrl;
    logic [CNT_WIDTH-1:0]  stall_count;

`ifdef PIPE_SKID_EN
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic                  skid_load;
    logic                  skid_clear;

    // Main refills from skid first to keep FIFO order; skid catches the input while main is held
    always_comb begin
        main_free      = !main_valid || OutReady;
        in_xfer        = InValid && !skid_valid;
        main_load      = !Flush && main_free && (skid_valid || in_xfer);
        main_clear     = Flush || (main_free && !skid_valid && !in_xfer);
        main_load_data = skid_valid ? skid_data : InData;
        main_load_ctrl = skid_valid ? skid_ctrl : InCtrl;
        skid_load      = !Flush && in_xfer && (skid_valid || !main_free);
        skid_clear     = Flush || (skid_valid && main_free && !in_xfer);
    end

    assign InReady = !skid_valid;

    pipe_slot #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CTRL_WIDTH   (CTRL_WIDTH),
        .CTRL_RST_VAL (CTRL_RST_VAL)
    ) u_skid (
        .clk       (CLK),
        .rst       (RST),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (InData),
        .load_ctrl (InCtrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
    );
`else
    // Single slot: accept whenever the slot is empty or draining this cycle
    always_comb begin
        main_free      = !main_valid || OutReady;
        in_xfer        = InValid && main_free;
        main_load      = !Flush && in_xfer;
        main_clear     = Flush || (main_free && !in_xfer);
        main_load_data = InData;
        main_load_ctrl = InCtrl;
    end

    assign InReady = main_free;
`endif

    pipe_slot #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CTRL_WIDTH   (CTRL_WIDTH),
        .CTRL_RST_VAL (CTRL_RST_VAL)
    ) u_main (
        .clk       (CLK),
        .rst       (RST),
        .load      (main_load),
        .clear     (main_clear),
        .load_data (main_load_data),
        .load_ctrl (main_load_ctrl),
        .valid     (main_valid),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

    // Count cycles where downstream refuses a valid entry, sticking at all-ones
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_count <= '0;
        end else if (main_valid && !OutReady && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

    assign OutValid   = main_valid;
    assign OutData    = main_data;
    assign OutCtrl    = main_ctrl;
    assign StallCount = stall_count;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard testbench for pipe_stage_reg. The reference model is a plain
// queue of accepted entries with capacity 1 (or 2 when PIPE_SKID_EN is defined).
module tb_pipe_stage_reg;

    localparam int              DW       = 128;
    localparam int              CW       = 16;
    localparam int              NW       = 4;
    localparam logic [CW-1:0]   RST_CTRL = 16'h0001;
    localparam int              CNT_MAX  = (1 << NW) - 1;
`ifdef PIPE_SKID_EN
    localparam bit              SKID     = 1'b1;
`else
    localparam bit              SKID     = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } entry_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Flush;
    logic          InValid;
    logic          InReady;
    logic [DW-1:0] InData;
    logic [CW-1:0] InCtrl;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutData;
    logic [CW-1:0] OutCtrl;
    logic [NW-1:0] StallCount;

    entry_t        expQ[$];
    logic [DW-1:0] lastData;
    int            stallModel;
    bit            modelLive    = 1'b0;
    bit            lastInXfer   = 1'b0;
    bit            expReady;
    int            preSize;
    int            checks       = 0;
    int            errors       = 0;
    int            streamStalls = 0;
    int            seenStalls   = 0;

    logic [DW-1:0] txData[$];
    bit            rdyPat[$];

    pipe_stage_reg #(
        .DATA_WIDTH   (DW),
        .CTRL_WIDTH   (CW),
        .CTRL_RST_VAL (RST_CTRL),
        .CNT_WIDTH    (NW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Flush      (Flush),
        .InValid    (InValid),
        .InReady    (InReady),
        .InData     (InData),
        .InCtrl     (InCtrl),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutData    (OutData),
        .OutCtrl    (OutCtrl),
        .StallCount (StallCount)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Monitor and reference model: check outputs, then advance the model by one edge
    always @(negedge CLK) begin
        preSize  = expQ.size();
        expReady = SKID ? (preSize < 2) : ((preSize == 0) || (OutReady == 1'b1));
        if (modelLive) begin
            checkOutput("in_ready", DW'(InReady), DW'(expReady));
            checkOutput("out_valid", DW'(OutValid), DW'(preSize != 0));
            checkOutput("stall_count", DW'(StallCount), DW'(stallModel));
            if (OutValid === 1'b1) begin
                if (preSize == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output at %0t: got data %0h, expected no entry", $time, OutData);
                end else begin
                    checkOutput("out_data", OutData, expQ[0].data);
                    checkOutput("out_ctrl", DW'(OutCtrl), DW'(expQ[0].ctrl));
                end
            end else begin
                checkOutput("bubble_ctrl", DW'(OutCtrl), DW'(RST_CTRL));
                checkOutput("held_data", OutData, lastData);
            end
            if (streamStalls != seenStalls) begin
                checks++;
                errors++;
                $display("[TB] FAIL stream_budget: %0d streams expired, expected 0", streamStalls);
                seenStalls = streamStalls;
            end
        end

        lastInXfer = 1'b0;
        if (RST === 1'b1) begin
            expQ.delete();
            stallModel = 0;
            lastData   = '0;
            modelLive  = 1'b1;
        end else if (modelLive) begin
            if ((preSize != 0) && !OutReady && (stallModel < CNT_MAX)) stallModel++;
            lastInXfer = InValid && expReady;
            if (Flush) begin
                expQ.delete();
            end else begin
                if ((preSize != 0) && OutReady) void'(expQ.pop_front());
                if (lastInXfer) expQ.push_back('{data: InData, ctrl: InCtrl});
            end
            if (expQ.size() != 0) lastData = expQ[0].data;
        end
    end

    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input bit rdy, input bit fl, input bit rs);
        InValid  = v;
        InData   = d;
        InCtrl   = c;
        OutReady = rdy;
        Flush    = fl;
        RST      = rs;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] randData();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Push every entry of txData through, holding each until accepted; OutReady follows rdyPat then stays high
    task automatic runStream(input int budget);
        int k;
        bit rdy;
        k = 0;
        while ((txData.size() > 0) && (k < budget)) begin
            rdy = (k < rdyPat.size()) ? rdyPat[k] : 1'b1;
            applyStimulus(1'b1, txData[0], 16'($urandom()), rdy, 1'b0, 1'b0);
            if (lastInXfer) void'(txData.pop_front());
            k++;
        end
        if (txData.size() > 0) begin
            streamStalls++;
            txData.delete();
        end
        rdyPat.delete();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with InValid asserted
        applyStimulus(1'b1, 128'h55, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 128'h55, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Back-to-back streaming with OutReady held high
        for (int i = 1; i <= 8; i++) txData.push_back(DW'(i));
        runStream(40);
        idle(3, 1'b1);

        // Backpressure while streaming A, B, C
        txData.push_back(128'hA);
        txData.push_back(128'hB);
        txData.push_back(128'hC);
        rdyPat.push_back(1'b1);
        for (int i = 0; i < 4; i++) rdyPat.push_back(1'b0);
        runStream(40);
        idle(5, 1'b1);

        // Fill the stage, then flush with a concurrent input 0xD
        applyStimulus(1'b1, 128'h21, 16'h1234, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 128'h22, 16'h5678, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 128'hD, 16'h9ABC, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Long stall to saturate the counter, then reset in the middle of it
        applyStimulus(1'b1, 128'h31, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 128'h32, 16'h0F0E, 1'b0, 1'b0, 1'b0);
        idle(20, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randData(), 16'($urandom()),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 199) == 0));
        end
        idle(5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
